// File: rtl/chan_cmd_responder.sv
// chan_cmd_responder
// Channel-side end of the Aurora command link. It takes one command frame from the
// RX AXI4-stream and performs one read or write on the local io_* bus. It then returns
// a two-beat response frame on the TX AXI4-stream.
//
// Ports
//   io_clk, io_reset             clock, asynchronous active-high reset
//   s_axis_*                     command frames in (header [31:28] op, [27:20] tag, [19:0] addr)
//   m_axis_*                     response frames out (header beat, then data/error-code beat)
//   io_sel/io_sync/io_rd_en/io_wr_en, io_addr, io_wr_data
//                                local programming bus strobes and payload
//   io_rd_data, io_rd_ack        local bus read return
//   cmd_count, err_count         saturating counts of successful / error responses
module chan_cmd_responder #(
    parameter int ACK_TIMEOUT = 256,
    parameter int CNT_W       = 16
) (
    input  logic             io_clk,
    input  logic             io_reset,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             io_sel,
    output logic             io_sync,
    output logic             io_rd_en,
    output logic             io_wr_en,
    output logic [19:0]      io_addr,
    output logic [31:0]      io_wr_data,
    input  logic [31:0]      io_rd_data,
    input  logic             io_rd_ack,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [3:0] OP_RD    = 4'd1;
    localparam logic [3:0] OP_WR    = 4'd2;
    localparam logic [3:0] ERR_OPC  = 4'd1;
    localparam logic [3:0] ERR_LEN  = 4'd2;
    localparam logic [3:0] ERR_TMO  = 4'd3;
    localparam logic [3:0] ERR_KEEP = 4'd4;

    typedef enum logic [2:0] {
        IDLE, GET_DATA, DRAIN, BUS_WR, BUS_RD, WAIT_ACK, SEND_HDR, SEND_DATA
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [7:0]       tag_q, tag_d;
    logic [19:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;     // write data, then captured read data
    logic [3:0]       err_q, err_d;       // 0 = no error latched
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic beat;
    logic keep_ok;

    assign s_axis_tready = (state_q == IDLE) || (state_q == GET_DATA) || (state_q == DRAIN);
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign keep_ok       = (s_axis_tkeep == 4'hF);

    // Every error is raised on a transition out of an error-free path (errors always
    // route to DRAIN/SEND_HDR), so the first error in a frame is never overwritten.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        cmd_cnt_d = cmd_cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: if (beat) begin
                op_d   = s_axis_tdata[31:28];
                tag_d  = s_axis_tdata[27:20];
                addr_d = s_axis_tdata[19:0];
                data_d = '0;
                err_d  = '0;
                if ((s_axis_tdata[31:28] != OP_RD) && (s_axis_tdata[31:28] != OP_WR)) begin
                    err_d   = ERR_OPC;
                    state_d = s_axis_tlast ? SEND_HDR : DRAIN;
                end else if (!keep_ok) begin
                    err_d   = ERR_KEEP;
                    state_d = s_axis_tlast ? SEND_HDR : DRAIN;
                end else if (s_axis_tdata[31:28] == OP_RD) begin
                    if (s_axis_tlast) begin
                        state_d = BUS_RD;
                    end else begin
                        err_d   = ERR_LEN;
                        state_d = DRAIN;
                    end
                end else begin
                    if (s_axis_tlast) begin
                        err_d   = ERR_LEN;
                        state_d = SEND_HDR;
                    end else begin
                        state_d = GET_DATA;
                    end
                end
            end
            GET_DATA: if (beat) begin
                data_d = s_axis_tdata;
                if (s_axis_tlast) begin
                    if (!keep_ok) begin
                        err_d   = ERR_KEEP;
                        state_d = SEND_HDR;
                    end else begin
                        state_d = BUS_WR;
                    end
                end else begin
                    err_d   = ERR_LEN;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (beat && s_axis_tlast) state_d = SEND_HDR;
            BUS_WR: state_d = SEND_HDR;
            BUS_RD: begin
                tmo_d = '0;
                if (io_rd_ack) begin
                    data_d  = io_rd_data;
                    state_d = SEND_HDR;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (io_rd_ack) begin
                    data_d  = io_rd_data;
                    state_d = SEND_HDR;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    err_d   = ERR_TMO;
                    state_d = SEND_HDR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SEND_HDR: if (m_axis_tready) state_d = SEND_DATA;
            SEND_DATA: if (m_axis_tready) begin
                state_d = IDLE;
                if (err_q != '0) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                end else begin
                    if (cmd_cnt_q != '1) cmd_cnt_d = cmd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge io_clk or posedge io_reset) begin
        if (io_reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            tag_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= '0;
            tmo_q     <= '0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            cmd_cnt_q <= cmd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Bus outputs decode straight from state; address/data are gated so the bus idles at 0.
    assign io_sel     = (state_q == BUS_WR) || (state_q == BUS_RD) || (state_q == WAIT_ACK);
    assign io_sync    = (state_q == BUS_WR) || (state_q == BUS_RD);
    assign io_rd_en   = (state_q == BUS_RD) || (state_q == WAIT_ACK);
    assign io_wr_en   = (state_q == BUS_WR);
    assign io_addr    = io_sel ? addr_q : '0;
    assign io_wr_data = io_wr_en ? data_q : '0;

    // Response beats come only from registers, so they stay stable under back-pressure.
    logic [31:0] hdr_word;
    logic [31:0] dat_word;
    assign hdr_word = {(err_q != '0) ? 4'hE : (op_q | 4'h8), tag_q, addr_q};
    assign dat_word = (err_q != '0) ? {28'h0, err_q} : ((op_q == OP_RD) ? data_q : 32'h0);

    assign m_axis_tvalid = (state_q == SEND_HDR) || (state_q == SEND_DATA);
    assign m_axis_tlast  = (state_q == SEND_DATA);
    assign m_axis_tkeep  = m_axis_tvalid ? 4'hF : 4'h0;
    assign m_axis_tdata  = (state_q == SEND_HDR)  ? hdr_word :
                           (state_q == SEND_DATA) ? dat_word : 32'h0;

    assign cmd_count = cmd_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_chan_cmd_responder.sv
module tb_chan_cmd_responder;

    logic        io_clk = 1'b0;
    logic        io_reset = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = 4'hF;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        io_sel, io_sync, io_rd_en, io_wr_en;
    logic [19:0] io_addr;
    logic [31:0] io_wr_data;
    logic [31:0] io_rd_data = '0;
    logic        io_rd_ack = 1'b0;
    logic [15:0] cmd_count, err_count;

    chan_cmd_responder #(.ACK_TIMEOUT(256), .CNT_W(16)) dut (
        .io_clk(io_clk), .io_reset(io_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .io_sel(io_sel), .io_sync(io_sync), .io_rd_en(io_rd_en), .io_wr_en(io_wr_en),
        .io_addr(io_addr), .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .io_rd_ack(io_rd_ack),
        .cmd_count(cmd_count), .err_count(err_count)
    );

    always #5 io_clk = ~io_clk;

    typedef struct packed { logic last; logic [31:0] data; } beat_t;
    typedef struct packed { logic wr; logic [19:0] addr; logic [31:0] wd; } bus_t;
    beat_t resp_q[$];
    bus_t  bus_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int exp_cmd = 0;
    int exp_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: valid&ready at the falling edge means the beat is taken at the next rising edge.
    always @(negedge io_clk) begin
        beat_t eb;
        bus_t  ev;
        if (!io_reset && m_axis_tvalid && m_axis_tready) begin
            if (resp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_resp: got %h expected no beat", m_axis_tdata);
            end else begin
                eb = resp_q.pop_front();
                chk("resp_data", m_axis_tdata, eb.data);
                chk("resp_last", m_axis_tlast, eb.last);
                chk("resp_keep", m_axis_tkeep, 4'hF);
            end
        end
        if (!io_reset && io_sync) begin
            if (bus_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_bus: got addr %h expected no access", io_addr);
            end else begin
                ev = bus_q.pop_front();
                chk("bus_sel", io_sel, 1);
                chk("bus_wr_en", io_wr_en, ev.wr);
                chk("bus_rd_en", io_rd_en, !ev.wr);
                chk("bus_addr", io_addr, ev.addr);
                chk("bus_wr_data", io_wr_data, ev.wd);
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 1000) begin @(negedge io_clk); n++; end
        if (n >= 1000) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: got tready 0 expected 1");
        end
        @(posedge io_clk);
        @(negedge io_clk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tkeep = 4'hF;
    endtask

    task automatic exp_resp(input logic [31:0] h, input logic [31:0] d);
        resp_q.push_back({1'b0, h});
        resp_q.push_back({1'b1, d});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || m_axis_tvalid) && n < 2000) begin @(negedge io_clk); n++; end
        if (n >= 2000) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_wait_timeout: got %0d beats pending expected 0", resp_q.size());
        end
        repeat (2) @(negedge io_clk);
        chk("cmd_count", cmd_count, exp_cmd);
        chk("err_count", err_count, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state
        repeat (3) @(negedge io_clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_io_sel", io_sel, 0);
        chk("rst_io_sync", io_sync, 0);
        chk("rst_io_addr", io_addr, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge io_clk);
        io_reset = 1'b0;
        @(negedge io_clk);

        // Write
        bus_q.push_back({1'b1, 20'h00010, 32'hCAFEF00D});
        exp_resp(32'hA0500010, 32'h0);
        send_beat(32'h20500010, 4'hF, 1'b0);
        send_beat(32'hCAFEF00D, 4'hF, 1'b1);
        exp_cmd = 1;
        wait_done();

        // Read acked 3 cycles after io_sync
        bus_q.push_back({1'b0, 20'h00004, 32'h0});
        exp_resp(32'h93C00004, 32'h12345678);
        send_beat(32'h13C00004, 4'hF, 1'b1);
        repeat (3) @(negedge io_clk);
        io_rd_data = 32'h12345678; io_rd_ack = 1'b1;
        @(negedge io_clk);
        io_rd_ack = 1'b0; io_rd_data = '0;
        exp_cmd = 2;
        wait_done();

        // Read timeout: BUS_RD, 256 WAIT_ACK cycles, then the header beat
        bus_q.push_back({1'b0, 20'h00004, 32'h0});
        exp_resp(32'hE3C00004, 32'h3);
        send_beat(32'h13C00004, 4'hF, 1'b1);
        k = 0;
        while (!m_axis_tvalid && k < 1000) begin @(negedge io_clk); k++; end
        chk("tmo_latency", k, 257);
        exp_err = 1;
        wait_done();
        io_rd_data = 32'h0BAD0BAD; io_rd_ack = 1'b1;
        @(negedge io_clk);
        io_rd_ack = 1'b0;
        repeat (3) @(negedge io_clk);
        chk("late_ack_tvalid", m_axis_tvalid, 0);
        chk("late_ack_tready", s_axis_tready, 1);

        // Unknown opcode, 3-beat frame drained
        exp_resp(32'hE11000AB, 32'h1);
        send_beat(32'h711000AB, 4'hF, 1'b0);
        send_beat(32'h00000001, 4'hF, 1'b0);
        send_beat(32'h00000002, 4'hF, 1'b1);
        exp_err = 2;
        wait_done();

        // Write with tlast on header
        exp_resp(32'hE2200100, 32'h2);
        send_beat(32'h22200100, 4'hF, 1'b1);
        exp_err = 3;
        wait_done();

        // Read header plus an extra beat
        exp_resp(32'hE3300200, 32'h2);
        send_beat(32'h13300200, 4'hF, 1'b0);
        send_beat(32'h00000055, 4'hF, 1'b1);
        exp_err = 4;
        wait_done();

        // Bad tkeep on a read header
        exp_resp(32'hE4400300, 32'h4);
        send_beat(32'h14400300, 4'h7, 1'b1);
        exp_err = 5;
        wait_done();

        // Back-pressure: header beat held 10 cycles
        m_axis_tready = 1'b0;
        bus_q.push_back({1'b1, 20'h00400, 32'hDEADBEEF});
        exp_resp(32'hA5500400, 32'h0);
        send_beat(32'h25500400, 4'hF, 1'b0);
        send_beat(32'hDEADBEEF, 4'hF, 1'b1);
        k = 0;
        while (!m_axis_tvalid && k < 50) begin @(negedge io_clk); k++; end
        chk("stall_tvalid", m_axis_tvalid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge io_clk);
            chk("stall_hold_data", m_axis_tdata, 32'hA5500400);
            chk("stall_hold_last", m_axis_tlast, 0);
        end
        @(posedge io_clk);
        #1 m_axis_tready = 1'b1;
        exp_cmd = 3;
        wait_done();

        // Reset during WAIT_ACK
        bus_q.push_back({1'b0, 20'h00500, 32'h0});
        send_beat(32'h16600500, 4'hF, 1'b1);
        repeat (3) @(negedge io_clk);
        chk("pre_rst_rd_en", io_rd_en, 1);
        io_reset = 1'b1;
        #1;
        chk("mid_rst_io_sel", io_sel, 0);
        chk("mid_rst_io_rd_en", io_rd_en, 0);
        chk("mid_rst_io_addr", io_addr, 0);
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_cmd_count", cmd_count, 0);
        chk("mid_rst_err_count", err_count, 0);
        @(negedge io_clk);
        io_reset = 1'b0;
        exp_cmd = 0; exp_err = 0;
        @(negedge io_clk);

        // Fresh frame after reset is decoded from its header
        bus_q.push_back({1'b1, 20'h00600, 32'h00000001});
        exp_resp(32'hA7700600, 32'h0);
        send_beat(32'h27700600, 4'hF, 1'b0);
        send_beat(32'h00000001, 4'hF, 1'b1);
        exp_cmd = 1;
        wait_done();

        chk("resp_q_empty", resp_q.size(), 0);
        chk("bus_q_empty", bus_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
